datapath_p2: RTL and testbench



---
 rtl/datapath_p2.sv | 189 ++++++++++++++++++
 tb/tb_datapath_p2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_p2.sv
// Mini SRC Phase-2 datapath: shared 32-bit bus, PC/IR/MAR/MDR/Y/Z/HI/LO, I/O ports, CON, 16x32 regfile, ALU.
// Latency: each register-transfer step is one Clock; bus, ALU and select/encode are combinational.
// Backpressure: none; the external controller sequences every enable and owns bus exclusivity.
// Ports: Clock/Clear (async active-low), *out = bus drive enables, *in = register load enables,
//   Gra/Grb/Grc/Rin/Rout/BAout/R15in = register-file select/encode, Mdatain/InPort_data = external
//   data in, outp = OutPort register contents.
module datapath_p2 (
  input  logic        Clock,
  input  logic        Clear,
  output logic [31:0] outp,
  input  logic        PCout,
  input  logic        Zhiout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOWout,
  input  logic        InPortout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOWin,
  input  logic        OutPortin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        R15in,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Cout,
  input  logic        CONIn,
  input  logic        Strobe,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InPort_data
);

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;

  logic [31:0] pc, ir, mar, mdr, y, hi, lo, in_port, out_port;
  logic [63:0] z;
  logic        con;
  logic [31:0] regs [16];

  logic [31:0] bus;
  logic [63:0] alu_res;

  // IR field decode
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc, sel_idx, wr_idx;
  logic [1:0]  c2;
  logic [31:0] c_sext;

  assign opcode  = ir[31:27];
  assign ra      = ir[26:23];
  assign rb      = ir[22:19];
  assign rc      = ir[18:15];
  assign c2      = ir[20:19];
  assign c_sext  = {{13{ir[18]}}, ir[18:0]};
  assign sel_idx = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);
  // jal link path: R15in steers the write to R15 regardless of the field select
  assign wr_idx  = R15in ? 4'd15 : sel_idx;

  assign outp = out_port;

  // MAR feeds external memory addressing only; Write is a pure memory strobe.
  logic unused_sig;
  assign unused_sig = Write ^ (^mar);

  // Bus source mux, highest priority first
  always_comb begin
    bus = '0;
    if (Rout)            bus = regs[sel_idx];
    else if (BAout)      bus = (sel_idx == 4'd0) ? '0 : regs[sel_idx];
    else if (PCout)      bus = pc;
    else if (MDRout)     bus = mdr;
    else if (Zhiout)     bus = z[63:32];
    else if (Zlowout)    bus = z[31:0];
    else if (HIout)      bus = hi;
    else if (LOWout)     bus = lo;
    else if (InPortout)  bus = in_port;
    else if (Cout)       bus = c_sext;
  end

  // ALU: A = Y, B = bus
  logic [31:0]        alu_a, alu_b;
  logic [4:0]         shamt;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  assign alu_a = y;
  assign alu_b = bus;
  assign shamt = alu_b[4:0];
  assign prod  = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});

  always_comb begin
    quo = '0;
    rem = '0;
    if (alu_b != 32'd0) begin
      quo = $signed(alu_a) / $signed(alu_b);
      rem = $signed(alu_a) % $signed(alu_b);
    end
  end

  always_comb begin
    alu_res = '0;
    if (IncPC) begin
      alu_res = {32'd0, alu_b + 32'd1};
    end else begin
      case (opcode)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR:
                         alu_res = {32'd0, alu_a + alu_b};
        OP_SUB:          alu_res = {32'd0, alu_a - alu_b};
        OP_SHR:          alu_res = {32'd0, alu_a >> shamt};
        OP_SHL:          alu_res = {32'd0, alu_a << shamt};
        // a shift by 32 yields 0, so shamt == 0 degenerates cleanly to A
        OP_ROR:          alu_res = {32'd0, (alu_a >> shamt) | (alu_a << (6'd32 - {1'b0, shamt}))};
        OP_ROL:          alu_res = {32'd0, (alu_a << shamt) | (alu_a >> (6'd32 - {1'b0, shamt}))};
        OP_AND, OP_ANDI: alu_res = {32'd0, alu_a & alu_b};
        OP_OR,  OP_ORI:  alu_res = {32'd0, alu_a | alu_b};
        OP_MUL:          alu_res = prod;
        OP_DIV:          alu_res = {rem, quo};
        OP_NEG:          alu_res = {32'd0, 32'd0 - alu_b};
        OP_NOT:          alu_res = {32'd0, ~alu_b};
        default:         alu_res = {32'd0, alu_b};
      endcase
    end
  end

  // Branch condition against the bus, selected by C2
  logic con_next;
  always_comb begin
    case (c2)
      2'b00:   con_next = (bus == 32'd0);
      2'b01:   con_next = (bus != 32'd0);
      2'b10:   con_next = ~bus[31];
      default: con_next = bus[31];
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc       <= '0;
      ir       <= '0;
      mar      <= '0;
      mdr      <= '0;
      y        <= '0;
      z        <= '0;
      hi       <= '0;
      lo       <= '0;
      in_port  <= '0;
      out_port <= '0;
      con      <= 1'b0;
    end else begin
      if (PCin)      pc       <= bus;
      if (IRin)      ir       <= bus;
      if (MARin)     mar      <= bus;
      if (MDRin)     mdr      <= Read ? Mdatain : bus;
      if (Yin)       y        <= bus;
      if (Zin)       z        <= alu_res;
      if (HIin)      hi       <= bus;
      if (LOWin)     lo       <= bus;
      if (Strobe)    in_port  <= InPort_data;
      if (OutPortin) out_port <= bus;
      if (CONIn)     con      <= con_next;
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (Rin || R15in) begin
      regs[wr_idx] <= bus;
    end
  end

endmodule

// File: tb/tb_datapath_p2.sv
// Directed + randomized bench for datapath_p2: register values are observed by routing them
// over the bus into OutPort and reading outp; ALU results come from a behavioural model.
module tb_datapath_p2;

  logic        Clock, Clear;
  logic [31:0] outp;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOWout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOWin, OutPortin;
  logic IncPC, Read, Write, R15in, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
  logic [31:0] Mdatain, InPort_data;

  int n_assert = 0;
  int n_fail   = 0;

  datapath_p2 dut (
    .Clock(Clock), .Clear(Clear), .outp(outp),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOWout(LOWout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOWin(LOWin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .R15in(R15in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONIn(CONIn), .Strobe(Strobe), .Mdatain(Mdatain), .InPort_data(InPort_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic clr_ctl();
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOWout, InPortout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOWin, OutPortin} = '0;
    {IncPC, Read, Write, R15in, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
  endtask

  // One RTN step: controls are set beforehand, sampled at the edge, cleared #1 after.
  task automatic tick();
    @(posedge Clock);
    #1;
    clr_ctl();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whatever source enable is already set is copied to OutPort, then outp is checked.
  task automatic rd(input string tag, input logic [31:0] exp);
    OutPortin = 1'b1;
    tick();
    chk(tag, outp, exp);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic set_ir(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; IRin = 1'b1;
    tick();
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [31:0] v);
    set_ir({5'd0, idx, 23'd0});
    load_mdr(v);
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    tick();
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] zlo, output logic [31:0] zhi);
    set_ir({op, 27'd0});
    load_mdr(a);
    MDRout = 1'b1; Yin = 1'b1; tick();
    load_mdr(b);
    MDRout = 1'b1; Zin = 1'b1; tick();
    Zlowout = 1'b1; OutPortin = 1'b1; tick(); zlo = outp;
    Zhiout  = 1'b1; OutPortin = 1'b1; tick(); zhi = outp;
  endtask

  // Reference ALU in plain arithmetic on integers
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] dbl;
    int          sh, sa, sb, q, r;
    longint      p;
    sh  = int'(b[4:0]);
    sa  = a;
    sb  = b;
    dbl = {a, a};
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18: return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a >> sh};
      5'd6:  return {32'd0, a << sh};
      5'd7:  begin dbl = dbl >> sh; return {32'd0, dbl[31:0]}; end
      5'd8:  begin dbl = dbl << sh; return {32'd0, dbl[63:32]}; end
      5'd9, 5'd12:  return {32'd0, a & b};
      5'd10, 5'd13: return {32'd0, a | b};
      5'd14: begin p = longint'(sa) * longint'(sb); return p; end
      5'd15: begin
        if (sb == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      5'd16: return {32'd0, -b};
      5'd17: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  logic [31:0] zl, zh, a, b;
  logic [63:0] exp64;
  logic [4:0]  op;
  logic [4:0]  ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd25};

  initial begin
    clr_ctl();
    Clear = 1'b0; Mdatain = '0; InPort_data = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_outp", outp, 32'd0);
    Clear = 1'b1;

    // --- populate state, then reset asynchronously mid-cycle ---
    load_mdr(32'hDEAD_BEEF);
    MDRout = 1'b1; PCin = 1'b1; LOWin = 1'b1; HIin = 1'b1; Yin = 1'b1; OutPortin = 1'b1;
    tick();
    chk("preload_outp", outp, 32'hDEAD_BEEF);
    InPort_data = 32'h0BAD_F00D; Strobe = 1'b1; tick();
    set_reg(4'd15, 32'h7777_7777);
    #2 Clear = 1'b0;
    #1 chk("async_reset_outp", outp, 32'd0);
    Read = 1'b1; MDRin = 1'b1; Mdatain = 32'hFFFF_FFFF; PCin = 1'b1; OutPortin = 1'b1;
    Strobe = 1'b1; Zin = 1'b1; IncPC = 1'b1;
    repeat (2) @(posedge Clock);
    #1 chk("reset_held_outp", outp, 32'd0);
    clr_ctl();
    Clear = 1'b1;
    PCout = 1'b1;     rd("reset_pc", 32'd0);
    MDRout = 1'b1;    rd("reset_mdr", 32'd0);
    HIout = 1'b1;     rd("reset_hi", 32'd0);
    LOWout = 1'b1;    rd("reset_lo", 32'd0);
    Zlowout = 1'b1;   rd("reset_zlo", 32'd0);
    Zhiout = 1'b1;    rd("reset_zhi", 32'd0);
    InPortout = 1'b1; rd("reset_inport", 32'd0);
    Gra = 1'b1; Rout = 1'b1; rd("reset_r0", 32'd0);   // IR = 0 selects R0
    Zin = 1'b1; tick();                                // IR opcode 0: Z = Y + 0
    Zlowout = 1'b1; rd("reset_y", 32'd0);
    set_ir({5'd0, 4'd15, 23'd0});
    Gra = 1'b1; Rout = 1'b1; rd("reset_r15", 32'd0);

    // --- mflo sequence ---
    load_mdr(32'd10);
    MDRout = 1'b1; LOWin = 1'b1; tick();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'hC100_0000; tick();
    MDRout = 1'b1; IRin = 1'b1; tick();
    Gra = 1'b1; Rin = 1'b1; LOWout = 1'b1; tick();
    Gra = 1'b1; Rout = 1'b1; rd("mflo_r2", 32'd10);
    PCout = 1'b1; rd("mflo_pc", 32'd1);
    Cout = 1'b1;  rd("mflo_ir_c", 32'd0);

    // --- add with wrap ---
    set_reg(4'd4, 32'd5);
    set_reg(4'd5, 32'hFFFF_FFFF);
    set_ir({5'b00011, 4'd0, 4'd4, 4'd5, 15'd0});
    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; tick();
    Zlowout = 1'b1; rd("add_zlo", 32'd4);
    Zhiout = 1'b1;  rd("add_zhi", 32'd0);

    // --- mul / div directed ---
    alu_run(5'b01110, 32'hFFFF_FFFA, 32'd4, zl, zh);
    chk("mul_zlo", zl, 32'hFFFF_FFE8);
    chk("mul_zhi", zh, 32'hFFFF_FFFF);
    alu_run(5'b01111, 32'd7, 32'd2, zl, zh);
    chk("div_zlo", zl, 32'd3);
    chk("div_zhi", zh, 32'd1);
    alu_run(5'b01111, 32'd9, 32'd0, zl, zh);
    chk("div0_zlo", zl, 32'd0);
    chk("div0_zhi", zh, 32'd0);

    // --- BAout / Cout ---
    set_reg(4'd0, 32'h55);
    Gra = 1'b1; BAout = 1'b1; rd("baout_r0", 32'd0);
    Gra = 1'b1; Rout = 1'b1;  rd("rout_r0", 32'h55);
    set_reg(4'd6, 32'h66);
    Gra = 1'b1; BAout = 1'b1; rd("baout_r6", 32'h66);
    set_ir(32'h0007_FFFF);
    Cout = 1'b1; rd("cout_neg", 32'hFFFF_FFFF);
    set_ir(32'h0003_FFFF);
    Cout = 1'b1; rd("cout_pos", 32'h0003_FFFF);

    // --- R15in link write ---
    load_mdr(32'hCAFE_0015);
    MDRout = 1'b1; R15in = 1'b1; tick();
    set_ir({5'd0, 4'd15, 23'd0});
    Gra = 1'b1; Rout = 1'b1; rd("r15in", 32'hCAFE_0015);

    // --- simultaneous read and write of MDR ---
    load_mdr(32'h1111);
    MDRout = 1'b1; LOWin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h2222; tick();
    LOWout = 1'b1; rd("rw_old", 32'h1111);
    MDRout = 1'b1; rd("rw_new", 32'h2222);

    // --- ports ---
    load_mdr(32'h1234);
    MDRout = 1'b1; OutPortin = 1'b1; tick();
    chk("outport", outp, 32'h1234);
    InPort_data = 32'h0000_ABCD; Strobe = 1'b1; tick();
    InPort_data = 32'h5555_5555;
    InPortout = 1'b1; rd("inport", 32'h0000_ABCD);

    // --- CON ---
    set_ir(32'd0);
    load_mdr(32'd0);
    MDRout = 1'b1; CONIn = 1'b1; tick();
    chk("con_eq_zero", {31'd0, dut.con}, 32'd1);
    load_mdr(32'd3);
    MDRout = 1'b1; CONIn = 1'b1; tick();
    chk("con_eq_three", {31'd0, dut.con}, 32'd0);
    set_ir(32'h0018_0000);                   // C2 = 11
    load_mdr(32'h8000_0000);
    MDRout = 1'b1; CONIn = 1'b1; tick();
    chk("con_neg", {31'd0, dut.con}, 32'd1);

    // --- randomized ALU against the model ---
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 19)];
      a  = $urandom;
      b  = $urandom;
      if (op == 5'd15) begin
        if ($urandom_range(0, 4) == 0) b = 32'd0;
        if (b == 32'hFFFF_FFFF) b = 32'd3;
      end
      exp64 = ref_alu(op, a, b);
      alu_run(op, a, b, zl, zh);
      chk($sformatf("rand_op%0d_zlo", op), zl, exp64[31:0]);
      chk($sformatf("rand_op%0d_zhi", op), zh, exp64[63:32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
